// File: rtl/fifo_reader_fsm.sv
// rtl/fifo_reader_fsm.sv - FIFO read-side controller with valid/ready output and burst marking
// Optional READER_PARITY_EN adds out_parity, even parity of out_data.
module fifo_reader_fsm #(
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_LEN   = 4,
  parameter int CNT_WIDTH   = 2,
  parameter int TOTAL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_rd,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic [TOTAL_WIDTH-1:0] words_sent
`ifdef READER_PARITY_EN
  ,
  output logic                   out_parity
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_PRESENT = 2'd3;

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic                 xfer;
  logic                 can_pop;

  assign xfer    = out_valid && out_ready;
  assign can_pop = en && !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:    state_nxt = can_pop ? S_REQ : S_IDLE;
      S_REQ:     state_nxt = S_WAIT;
      S_WAIT:    state_nxt = S_PRESENT;
      S_PRESENT: begin
        if (xfer) begin
          state_nxt = can_pop ? S_REQ : S_IDLE;
        end else begin
          state_nxt = S_PRESENT;
        end
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  // All handshake outputs decode from the registered state, so reset clears them at once.
  always_comb begin
    fifo_rd   = (state == S_REQ);
    out_valid = (state == S_PRESENT);
    busy      = (state != S_IDLE);
    out_last  = out_valid && (beat_cnt == LAST_BEAT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
`ifdef READER_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else if (state == S_WAIT) begin
      out_data <= fifo_data;
`ifdef READER_PARITY_EN
      out_parity <= ^fifo_data;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt   <= '0;
      words_sent <= '0;
    end else if (xfer) begin
      words_sent <= words_sent + TOTAL_WIDTH'(1);
      beat_cnt   <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_reader_fsm.sv
// tb/tb_fifo_reader_fsm.sv - directed vector bench for fifo_reader_fsm
module tb_fifo_reader_fsm;

  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          fifo_empty;
  logic [7:0]    fifo_data = 8'h00;
  logic          fifo_rd;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;
  logic [TW-1:0] words_sent;
`ifdef READER_PARITY_EN
  logic          out_parity;
`endif

  int total = 0;
  int bad = 0;

  fifo_reader_fsm #(
    .DATA_WIDTH(8), .BURST_LEN(4), .CNT_WIDTH(2), .TOTAL_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .words_sent(words_sent)
`ifdef READER_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  // Registered-read FIFO model; pops on an empty FIFO are counted as underflows.
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_count = 0;
  int underflow = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd) begin
      rd_count = rd_count + 1;
      if (rd_ptr == wr_ptr) begin
        underflow = underflow + 1;
      end else begin
        fifo_data <= mem[rd_ptr % 64];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  typedef struct {
    logic          en;
    logic          rdy;
    logic          exp_rd;
    logic          exp_valid;
    logic [7:0]    exp_data;
    logic          exp_last;
    logic          exp_busy;
    logic [TW-1:0] exp_words;
  } vec_t;

  vec_t vecs [0:21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 64] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    en = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      en = vecs[i].en;
      out_ready = vecs[i].rdy;
      check($sformatf("row%0d fifo_rd", i), 32'(fifo_rd), 32'(vecs[i].exp_rd));
      check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("row%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
      check($sformatf("row%0d out_last", i), 32'(out_last), 32'(vecs[i].exp_last));
      check($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("row%0d words_sent", i), 32'(words_sent), 32'(vecs[i].exp_words));
    end
  endtask

  initial begin
    int rc;
    // Single word 0x3C: IDLE, REQ, WAIT, PRESENT, IDLE.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 4'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 4'd1};
    // Burst 0x01..0x05: last only on the 4th word, pops every 3 cycles.
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4'd0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 4'd0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 4'd1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 4'd1};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 4'd1};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 4'd2};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 1'b0, 1'b1, 4'd2};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 4'd2};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 4'd3};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1, 4'd3};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 4'd3};
    vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h04, 1'b0, 1'b1, 4'd4};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h04, 1'b0, 1'b1, 4'd4};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 4'd4};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 4'd5};

    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Async reset while presenting 0xA5.
    do_reset();
    push(8'hA5);
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst out_valid", 32'(out_valid), 32'd1);
    check("pre_rst out_data", 32'(out_data), 32'hA5);
    rst = 1'b1;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst fifo_rd", 32'(fifo_rd), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst out_last", 32'(out_last), 32'd0);
    check("rst words_sent", 32'(words_sent), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst fifo_rd", 32'(fifo_rd), 32'd0);
    check("post_rst busy", 32'(busy), 32'd0);
    check("post_rst fifo_empty", 32'(fifo_empty), 32'd1);

    do_reset();
    push(8'h3C);
    run_rows(0, 4);

    do_reset();
    for (int i = 1; i <= 5; i++) push(8'(i));
    run_rows(5, 21);

    // Stall for 10 cycles with a second word waiting in the FIFO.
    do_reset();
    push(8'h77);
    push(8'h88);
    en = 1'b1;
    repeat (3) @(negedge clk);
    rc = rd_count;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall out_valid", 32'(out_valid), 32'd1);
      check("stall out_data", 32'(out_data), 32'h77);
      check("stall fifo_rd", 32'(fifo_rd), 32'd0);
    end
    check("stall pops", 32'(rd_count), 32'(rc));
    out_ready = 1'b1;
    @(negedge clk);
    check("stall words_sent", 32'(words_sent), 32'd1);
    check("stall next fifo_rd", 32'(fifo_rd), 32'd1);
    repeat (2) @(negedge clk);
    check("stall 2nd out_data", 32'(out_data), 32'h88);
    @(negedge clk);
    check("stall idle busy", 32'(busy), 32'd0);
    check("stall words_sent 2", 32'(words_sent), 32'd2);

    // Enable dropped during WAIT of 0x11.
    do_reset();
    push(8'h11);
    push(8'h22);
    en = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("endrop out_valid", 32'(out_valid), 32'd1);
    check("endrop out_data", 32'(out_data), 32'h11);
    @(negedge clk);
    check("endrop idle busy", 32'(busy), 32'd0);
    check("endrop words_sent", 32'(words_sent), 32'd1);
    rc = rd_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("endrop fifo_rd", 32'(fifo_rd), 32'd0);
    end
    check("endrop pops", 32'(rd_count), 32'(rc));
    en = 1'b1;
    @(negedge clk);
    check("endrop resume fifo_rd", 32'(fifo_rd), 32'd1);
    repeat (2) @(negedge clk);
    check("endrop 2nd out_data", 32'(out_data), 32'h22);
    @(negedge clk);

    // Parity words 0x07 and 0x03.
    do_reset();
    push(8'h07);
    push(8'h03);
    en = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("par 07 out_data", 32'(out_data), 32'h07);
`ifdef READER_PARITY_EN
    check("par 07 out_parity", 32'(out_parity), 32'd1);
`endif
    repeat (3) @(negedge clk);
    check("par 03 out_data", 32'(out_data), 32'h03);
`ifdef READER_PARITY_EN
    check("par 03 out_parity", 32'(out_parity), 32'd0);
`endif
    @(negedge clk);

    // words_sent wraps after 16 transfers with a 4-bit counter.
    do_reset();
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
    en = 1'b1;
    out_ready = 1'b1;
    for (int n = 1; n <= 49; n++) begin
      @(negedge clk);
      if (n == 48) begin
        check("wrap pre words_sent", 32'(words_sent), 32'd15);
        check("wrap last out_data", 32'(out_data), 32'h4F);
      end
      if (n == 49) begin
        check("wrap words_sent", 32'(words_sent), 32'd0);
        check("wrap busy", 32'(busy), 32'd0);
      end
    end

    check("underflow", 32'(underflow), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_reader_fsm.md
Name: fifo_reader_fsm

Overview:
FSM-based read-side controller for the team's 8-bit synchronous FIFO. It pops words whenever the FIFO is non-empty and enabled, and presents each word downstream on a valid/ready handshake. It groups the words into bursts of BURST_LEN and flags the last word of each burst. It sits between the FIFO's read port and any consumer that may stall.

Parameters:
DATA_WIDTH, 8, width of FIFO data and out_data
BURST_LEN, 4, words per burst; must be >= 2
CNT_WIDTH, 2, width of beat counter; must satisfy 2**CNT_WIDTH >= BURST_LEN
TOTAL_WIDTH, 16, width of words_sent counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
en  input  1  enable new pops; sampled in IDLE and PRESENT
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_WIDTH  FIFO registered read data; valid the cycle after fifo_rd
fifo_rd  output  1  FIFO read strobe, one cycle per word
out_data  output  DATA_WIDTH  word presented downstream
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts when out_valid && out_ready
out_last  output  1  current word is the last of a burst
busy  output  1  state != IDLE
words_sent  output  TOTAL_WIDTH  count of completed downstream transfers

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - fifo_rd, out_valid, out_last, busy = 0.
  - out_data, beat_cnt, words_sent = 0.
  - A word already popped but not transferred is discarded.
- States: IDLE, REQ, WAIT, PRESENT. Use a registered state with encoded constants.
- IDLE: if en && !fifo_empty, go to REQ; otherwise stay.
- REQ: fifo_rd=1 (decoded from state, this state only); go to WAIT unconditionally.
- WAIT: fifo_data is valid this cycle. At the edge, out_data<=fifo_data and go to PRESENT.
- PRESENT:
  - out_valid=1; out_data is held stable until transfer.
  - On out_valid && out_ready (transfer):
    - words_sent+1, wrapping modulo 2**TOTAL_WIDTH.
    - beat_cnt+1, wrapping to 0 after BURST_LEN-1.
    - Next state is REQ if en && !fifo_empty, else IDLE.
  - No transfer: stay in PRESENT, all outputs held.
- out_last = out_valid && (beat_cnt == BURST_LEN-1); combinational from registered state.
- Latency:
  - Non-empty seen in IDLE -> fifo_rd next cycle -> out_valid 3 cycles after the IDLE sample.
  - Back-to-back throughput with out_ready=1 is 1 word per 3 cycles (PRESENT->REQ->WAIT->PRESENT).
- fifo_rd is never asserted when fifo_empty was 1 at the deciding edge. At most one pop is outstanding.
- en deasserted mid-word: REQ/WAIT/PRESENT complete normally, the word is still delivered, then the FSM returns to IDLE. beat_cnt is not cleared by en.
- fifo_empty rising during WAIT/PRESENT: no effect on the in-flight word.
- Downstream stall of any length: no extra pop occurs and the FIFO is untouched.
- Illegal state encodings go to IDLE.

Optional Feature:
- Macro: READER_PARITY_EN.
- Defined:
  - Adds output out_parity (1 bit) = XOR of out_data (even parity), registered with out_data at the WAIT edge.
  - Reset value 0; held stable with out_data.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. Reset: assert rst mid-PRESENT with out_data=0xA5 -> all outputs 0 immediately (async); after release the FSM is in IDLE and fifo_rd=0 while fifo_empty=1.
2. Single word: FIFO holds 0x3C, en=1, out_ready=1 -> fifo_rd high exactly 1 cycle; out_valid high 2 cycles later with out_data=0x3C; words_sent=1; out_last=0.
3. Burst of 5 words 0x01..0x05, out_ready=1:
   - out_last=1 only on 0x04 (4th word), then 0 on 0x05.
   - beat_cnt wraps to 0 after 0x04.
   - words_sent=5; fifo_rd pulses spaced 3 cycles apart.
4. Stall: out_ready=0 for 10 cycles with word 0x77 presented -> out_data and out_valid held; no fifo_rd pulses. Raise out_ready -> one transfer, words_sent+1.
5. Enable drop: deassert en during WAIT of word 0x11 with more data in FIFO -> 0x11 delivered, then IDLE, no further fifo_rd until en=1.
6. words_sent wrap: preload via 65536 transfers (or TOTAL_WIDTH=4 with 16 transfers) -> counter returns to 0. With READER_PARITY_EN, 0x07 -> out_parity=1 and 0x03 -> out_parity=0.
